// File: rtl/digit_scan_pkg.sv
// Shared definitions for the 4-digit scan multiplexer: channel count,
// select width and the BLANK/SHOW state encoding.
package digit_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Advance the channel select; 3 wraps to 0 by natural overflow of SEL_W bits.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    return sel + 1'b1;
  endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Bus between the BCD/clock logic and the per-digit demux/segment driver.
// master: the scanner (consumes channel data and mask, drives select/enable/data/frame).
// slave:  the surrounding logic (supplies channel data and mask, observes outputs).
import digit_scan_pkg::*;

interface digit_scan_mux_if #(
  parameter int DATA_W = 4
);

  logic [NUM_CH*DATA_W-1:0] i_ch_data;
  logic [NUM_CH-1:0]        i_mask;
  logic [SEL_W-1:0]         o_sel;
  logic                     o_ena;
  logic [DATA_W-1:0]        o_data;
  logic                     o_frame;

  modport master (
    input  i_ch_data,
    input  i_mask,
    output o_sel,
    output o_ena,
    output o_data,
    output o_frame
  );

  modport slave (
    output i_ch_data,
    output i_mask,
    input  o_sel,
    input  o_ena,
    input  o_data,
    input  o_frame
  );

endinterface

// File: rtl/digit_scan_mux_scan_timer.sv
// Slot timer for the scan multiplexer: a down-counter that reloads itself on
// terminal count with either the blank length or the show length.
// It resets loaded with the blank length so the first BLANK lasts the full
// BLANK_LEN cycles. Counter width is derived here and nowhere else.
module scan_timer #(
  parameter int BLANK_LEN = 120,
  parameter int SHOW_LEN  = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_show,
  output logic tc
);

  localparam int MAX_LEN = (SHOW_LEN > BLANK_LEN) ? SHOW_LEN : BLANK_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_LEN - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_LEN - 1);

  logic [CNT_W-1:0] count;

  assign tc = (count == '0);

  // Count down to zero, then reload with the length of the upcoming phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= BLANK_LOAD;
    end else if (tc) begin
      count <= load_show ? SHOW_LOAD : BLANK_LOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexing digit scanner. Walks a 2-bit select through four
// channels; each slot is BLANK_CYCLES of dead time followed by DWELL_CYCLES
// of display. On entry to SHOW the selected channel's data, its mask bit and
// a frame marker are captured together, so mid-slot input changes never
// reach the outputs.
// Optional build macro: DIGIT_SCAN_LZB_EN enables leading-zero blanking
// (channel n >= 1 stays dark when channels n..3 are all zero).
// DWELL_CYCLES and BLANK_CYCLES must both be >= 1.
import digit_scan_pkg::*;

module digit_scan_mux #(
  parameter int DATA_W       = 4,
  parameter int DWELL_CYCLES = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  digit_scan_mux_if.master bus
);

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ena_q, ena_d;
  logic              frame_q, frame_d;

  logic              tc;
  logic              lzb_dark;
  logic [DATA_W-1:0] ch [NUM_CH];

  // Unpack the flat channel bus into one word per channel.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
    assign ch[n] = bus.i_ch_data[n*DATA_W +: DATA_W];
  end

  scan_timer #(
    .BLANK_LEN (BLANK_CYCLES),
    .SHOW_LEN  (DWELL_CYCLES)
  ) u_timer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load_show (state_q == BLANK),
    .tc        (tc)
  );

`ifdef DIGIT_SCAN_LZB_EN
  logic [NUM_CH-1:0] zero_up;

  // zero_up[n] is set when channels n..3 all hold zero in the live input.
  always_comb begin
    zero_up = '0;
    zero_up[NUM_CH-1] = (ch[NUM_CH-1] == '0);
    for (int n = NUM_CH-2; n >= 0; n--) begin
      zero_up[n] = zero_up[n+1] && (ch[n] == '0);
    end
  end

  assign lzb_dark = (sel_q != '0) && zero_up[sel_q];
`else
  assign lzb_dark = 1'b0;
`endif

  // Next-state and snapshot logic; outputs hold unless a phase boundary is reached.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ena_d   = ena_q;
    frame_d = 1'b0;
    case (state_q)
      BLANK: begin
        ena_d = 1'b0;
        if (tc) begin
          state_d = SHOW;
          data_d  = ch[sel_q];
          ena_d   = bus.i_mask[sel_q] & ~lzb_dark;
          frame_d = (sel_q == '0);
        end
      end
      SHOW: begin
        if (tc) begin
          state_d = BLANK;
          sel_d   = next_sel(sel_q);
          ena_d   = 1'b0;
        end
      end
      default: begin
        state_d = BLANK;
        ena_d   = 1'b0;
      end
    endcase
  end

  // Register the FSM state and every output so the display path sees clean edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BLANK;
      sel_q   <= '0;
      data_q  <= '0;
      ena_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      frame_q <= frame_d;
    end
  end

  assign bus.o_sel   = sel_q;
  assign bus.o_ena   = ena_q;
  assign bus.o_data  = data_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux with DWELL=4, BLANK=2, DATA_W=4.
// A timeline model derived from the edge count since reset release pushes
// the expected outputs for every clock edge; each scenario pops and compares.
// Honours DIGIT_SCAN_LZB_EN when defined.
module tb_digit_scan_mux;

  localparam int DW    = 4;
  localparam int DWELL = 4;
  localparam int BLNK  = 2;
  localparam int SLOT  = DWELL + BLNK;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [1:0] sel;
    logic       ena;
    logic [3:0] data;
    logic       frame;
  } exp_t;

  logic clk;
  logic rst_n;
  digit_scan_mux_if #(.DATA_W(DW)) bus ();

  digit_scan_mux #(
    .DATA_W       (DW),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLNK)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   passed;
  int   total;
  int   n_edges;
  logic [3:0] m_data;
  logic       m_ena;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Leading-zero blanking reference: dark if the channel lies above the highest nonzero digit.
  function automatic logic model_dark(input logic [15:0] d, input int s);
`ifdef DIGIT_SCAN_LZB_EN
    int hi;
    hi = -1;
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] != 4'h0) hi = i;
    return (s != 0) && (s > hi);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t observed();
    return {bus.o_sel, bus.o_ena, bus.o_data, bus.o_frame};
  endfunction

  // Advance one clock edge, update the timeline model and queue the expected outputs.
  task automatic tick();
    exp_t e;
    int   pos;
    int   s;
    @(posedge clk);
    n_edges++;
    pos = n_edges % SLOT;
    s   = (n_edges / SLOT) % 4;
    if (pos == BLNK) begin
      m_data = bus.i_ch_data[s*4 +: 4];
      m_ena  = bus.i_mask[s] & ~model_dark(bus.i_ch_data, s);
    end
    e.sel   = 2'(s);
    e.ena   = (pos >= BLNK) ? m_ena : 1'b0;
    e.data  = m_data;
    e.frame = (pos == BLNK) && (s == 0);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic model_reset();
    n_edges = 0;
    m_data  = 4'h0;
    m_ena   = 1'b0;
    exp_q.delete();
  endtask

  // Run forward without comparing until the next frame boundary (start of slot 0 blank).
  task automatic align_frame();
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      if (n_edges % FRAME == 0) break;
      tick();
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n         = 1'b0;
    bus.i_ch_data = 16'h4321;
    bus.i_mask    = 4'hF;
    #12;
    o = observed();
    total++;
    if (o !== '0) $display("[TB] FAIL reset_state: got %h want 0", o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_slots();
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) $display("[TB] FAIL first_slots edge %0d: got sel=%0d ena=%0b data=%h frame=%0b want sel=%0d ena=%0b data=%h frame=%0b",
                            n_edges, o.sel, o.ena, o.data, o.frame, e.sel, e.ena, e.data, e.frame);
      else passed++;
    end
  endtask

  task automatic test_free_run();
    exp_t e, o;
    int   last_frame;
    int   pulses;
    last_frame = -1;
    pulses     = 0;
    for (int i = 0; i < 54; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) $display("[TB] FAIL free_run edge %0d: got sel=%0d ena=%0b data=%h frame=%0b want sel=%0d ena=%0b data=%h frame=%0b",
                            n_edges, o.sel, o.ena, o.data, o.frame, e.sel, e.ena, e.data, e.frame);
      else passed++;
      if (bus.o_frame === 1'b1) begin
        if (last_frame >= 0) begin
          total++;
          if (n_edges - last_frame != FRAME)
            $display("[TB] FAIL frame_spacing: got %0d want %0d", n_edges - last_frame, FRAME);
          else passed++;
        end
        last_frame = n_edges;
        pulses++;
      end
    end
    total++;
    if (pulses < 2) $display("[TB] FAIL frame_pulses: got %0d want >=2", pulses);
    else passed++;
  endtask

  task automatic test_mask();
    exp_t e, o;
    int   lit;
    int   dark_sel2;
    align_frame();
    bus.i_mask = 4'b1011;
    lit        = 0;
    dark_sel2  = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) $display("[TB] FAIL mask edge %0d: got sel=%0d ena=%0b data=%h frame=%0b want sel=%0d ena=%0b data=%h frame=%0b",
                            n_edges, o.sel, o.ena, o.data, o.frame, e.sel, e.ena, e.data, e.frame);
      else passed++;
      if (o.ena === 1'b1) lit++;
      if (o.sel == 2'd2 && (n_edges % SLOT) >= BLNK && o.ena === 1'b0) dark_sel2++;
    end
    total++;
    if (lit != 3 * DWELL) $display("[TB] FAIL mask_lit_cycles: got %0d want %0d", lit, 3 * DWELL);
    else passed++;
    total++;
    if (dark_sel2 != DWELL) $display("[TB] FAIL mask_dark_slot2: got %0d want %0d", dark_sel2, DWELL);
    else passed++;
    bus.i_mask = 4'hF;
  endtask

  task automatic test_data_hold();
    exp_t e, o;
    int   saw9;
    align_frame();
    for (int i = 0; i < BLNK + 2; i++) begin
      tick();
      e = exp_q.pop_front();
    end
    bus.i_ch_data = 16'h4329;
    saw9 = 0;
    for (int i = 0; i < FRAME + SLOT; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) $display("[TB] FAIL data_hold edge %0d: got sel=%0d ena=%0b data=%h frame=%0b want sel=%0d ena=%0b data=%h frame=%0b",
                            n_edges, o.sel, o.ena, o.data, o.frame, e.sel, e.ena, e.data, e.frame);
      else passed++;
      if (o.sel == 2'd0 && o.ena === 1'b1 && o.data == 4'h9) saw9++;
    end
    total++;
    if (saw9 != DWELL) $display("[TB] FAIL data_hold_new_value: got %0d cycles of 9 want %0d", saw9, DWELL);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    align_frame();
    for (int i = 0; i < 2 * SLOT + BLNK + 1; i++) begin
      tick();
      e = exp_q.pop_front();
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = observed();
    total++;
    if (o !== '0) $display("[TB] FAIL reset_mid_immediate: got %h want 0", o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) $display("[TB] FAIL reset_mid_restart edge %0d: got sel=%0d ena=%0b data=%h frame=%0b want sel=%0d ena=%0b data=%h frame=%0b",
                            n_edges, o.sel, o.ena, o.data, o.frame, e.sel, e.ena, e.data, e.frame);
      else passed++;
    end
  endtask

  task automatic test_lzb();
    exp_t        e, o;
    logic [15:0] pats [3];
    pats[0] = 16'h0005;
    pats[1] = 16'h0050;
    pats[2] = 16'h0000;
    for (int p = 0; p < 3; p++) begin
      align_frame();
      bus.i_ch_data = pats[p];
      for (int i = 0; i < FRAME; i++) begin
        tick();
        e = exp_q.pop_front();
        o = observed();
        total++;
        if (o !== e) $display("[TB] FAIL lzb pat=%h edge %0d: got sel=%0d ena=%0b data=%h frame=%0b want sel=%0d ena=%0b data=%h frame=%0b",
                              pats[p], n_edges, o.sel, o.ena, o.data, o.frame, e.sel, e.ena, e.data, e.frame);
        else passed++;
      end
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    n_edges = 0;
    m_data  = 4'h0;
    m_ena   = 1'b0;
    $display("[TB] starting digit_scan_mux bench");
    test_reset();
    test_first_slots();
    test_free_run();
    test_mask();
    test_data_hold();
    test_reset_mid();
    test_lzb();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Time-multiplexing scanner; the producing end of the 1-to-4 select/enable demux path.
- Cycles a 2-bit select through four channels.
- Snapshots the selected channel's data onto a single shared bus and drives a registered enable.
- Sits between clock/BCD logic (four digit values) and the per-digit demux/segment driver of the 4-digit display.

Parameters:
- DATA_W, 4: width of each channel's data.
- DWELL_CYCLES, 12000: clock cycles each channel is shown (1 ms at 12 MHz); must be >= 1.
- BLANK_CYCLES, 120: dead-time cycles between channels (ghosting suppression); must be >= 1.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ch_data  in  4*DATA_W  channel n at [n*DATA_W +: DATA_W].
- i_mask  in  4  per-channel display enable; 0 = slot runs, output stays dark.
- o_sel  out  2  current channel index.
- o_ena  out  1  channel active (feeds demux enable).
- o_data  out  DATA_W  snapshotted data of the current channel.
- o_frame  out  1  one-cycle pulse at start of the channel-0 SHOW.

Behaviour:
- Reset (async assert, sync release use): state=BLANK, counter=0, o_sel=0, o_ena=0, o_data=0, o_frame=0.
- Reset mid-operation aborts immediately; scanning restarts at channel 0.
- States:
  - BLANK: o_ena=0; counter counts 0..BLANK_CYCLES-1; at terminal count, next state=SHOW, counter=0.
  - SHOW: counter counts 0..DWELL_CYCLES-1; at terminal count, next state=BLANK, counter=0, o_sel<=o_sel+1 mod 4 (3 wraps to 0).
- On the BLANK->SHOW edge, all registered together:
  - o_data <= i_ch_data slice[o_sel].
  - o_ena <= i_mask[o_sel].
  - o_frame <= (o_sel==0); o_frame is cleared the following cycle.
- o_data holds through SHOW and BLANK; input changes during a slot are never visible until that channel's next snapshot.
- First SHOW starts BLANK_CYCLES cycles after reset release.
- Slot period = BLANK_CYCLES+DWELL_CYCLES; frame period = 4x slot period.
- A masked slot keeps full timing, so refresh rate is independent of i_mask.
- Counter width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); no overflow possible.
- i_mask is sampled only at snapshot; changes mid-slot take effect at the next slot.

Optional Feature:
- Macro: DIGIT_SCAN_LZB_EN (leading-zero blanking).
- Defined: at snapshot, channel n (n>=1) is forced dark (o_ena=0) when channels 3..n are all zero in the current i_ch_data. Channel 0 is never blanked. Mask still applies (AND).
- Undefined: o_ena depends only on i_mask; zero digits are displayed.

Decomposition:
- Package digit_scan_pkg: NUM_CH=4, SEL_W=2, state typedef {BLANK, SHOW}.
- Sub-module scan_timer: parameterised down-counter with load value and terminal-count strobe; owns counter width.
- digit_scan_mux keeps the FSM, select, snapshot and LZB logic.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, DATA_W=4):
- Release reset with i_ch_data=16'h4321, i_mask=4'hF -> o_ena=0 for 2 cycles; then 4 cycles o_ena=1, o_sel=0, o_data=1, o_frame high only first cycle; next 2 cycles o_ena=0 with o_sel=1 and o_data=1 held; then o_data=2.
- Free-run 30 cycles -> sel sequence 0,1,2,3,0; o_frame pulses exactly 24 cycles apart; data 1,2,3,4,1.
- i_mask=4'b1011 -> slot sel=2 spans 4 cycles with o_ena=0; all slot timings identical to unmasked.
- Change ch0 1->9 at SHOW cycle 2 -> o_data stays 1 until slot ends; next frame shows 9.
- Assert i_rst_n low during sel=2 SHOW -> o_ena/o_sel/o_data/o_frame zero immediately (before next edge); after release, first SHOW is sel=0 after 2 cycles.
- With DIGIT_SCAN_LZB_EN: data 16'h0005 -> o_ena only in slot 0; 16'h0050 -> slots 0,1; 16'h0000 -> slot 0 only, o_data=0.
